// File: rtl/speed_ctrl.sv
// speed_ctrl: playback speed controller for the audio recorder datapath.
//   Keeps a signed speed index s (fast when s >= 0, slow when s < 0), moved by
//   up/down/norm key pulses with saturation and a lock level. For every output
//   sample tick it produces the SRAM address step and, in slow mode, the
//   interpolation fraction used by the DSP block.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_up, i_down     one step faster / slower (single-cycle pulses)
//   i_norm           return to 1x (single-cycle pulse)
//   i_lock           level; ignores i_up, i_down and i_norm while high
//   i_tick           output-sample request (single-cycle pulse)
//   o_fast_or_slow   1 = fast or normal, 0 = slow
//   o_speed          current factor, 1..MAX_FACTOR
//   o_adv            pulse: advance sample address by o_step
//   o_step           address increment
//   o_frac           interpolation numerator 0..o_speed-1
//   o_valid          pulse one cycle after each i_tick
module speed_ctrl #(
    parameter int MAX_FACTOR = 8,
    parameter int SPEED_W    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_norm,
    input  logic               i_lock,
    input  logic               i_tick,
    output logic               o_fast_or_slow,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_adv,
    output logic [SPEED_W-1:0] o_step,
    output logic [SPEED_W-1:0] o_frac,
    output logic               o_valid
);
    // One extra bit so the index can carry a sign alongside SPEED_W magnitude bits.
    localparam logic signed [SPEED_W:0] S_MAX = (SPEED_W+1)'(MAX_FACTOR - 1);
    localparam logic signed [SPEED_W:0] S_MIN = -S_MAX;
    localparam logic signed [SPEED_W:0] S_ONE = (SPEED_W+1)'(1);
    localparam logic [SPEED_W-1:0]      ONE   = SPEED_W'(1);

    logic signed [SPEED_W:0] s, s_next;
    logic [SPEED_W-1:0]      p, p_next, mag;
    logic                    slow, wrap;

    always_comb begin
        slow   = s[SPEED_W];
        mag    = slow ? SPEED_W'(-s) : s[SPEED_W-1:0];
        // Slow factor is F = |s|+1, so the last phase of a period is p == |s|.
        wrap   = (p == mag);
        s_next = s;
        if (!i_lock) begin
            if (i_norm)
                s_next = '0;
            else if (i_up && !i_down)
                s_next = (s == S_MAX) ? s : s + S_ONE;
            else if (i_down && !i_up)
                s_next = (s == S_MIN) ? s : s - S_ONE;
        end
        p_next = p;
        if (i_tick)
            p_next = (slow && !wrap) ? p + ONE : '0;
        // A speed change restarts the interpolation period; it overrides the tick increment.
        if (s_next != s)
            p_next = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s              <= '0;
            p              <= '0;
            o_fast_or_slow <= 1'b1;
            o_speed        <= ONE;
            o_adv          <= 1'b0;
            o_step         <= '0;
            o_frac         <= '0;
            o_valid        <= 1'b0;
        end else begin
            s              <= s_next;
            p              <= p_next;
            o_fast_or_slow <= !slow;
            o_speed        <= mag + ONE;
            o_valid        <= i_tick;
            o_adv          <= i_tick && (!slow || wrap);
            if (i_tick) begin
                o_step <= slow ? ONE : s[SPEED_W-1:0] + ONE;
                o_frac <= slow ? p : '0;
            end
        end
    end
endmodule

// File: doc/speed_ctrl.md
Name: speed_ctrl

Overview:
- Playback speed controller for the audio recorder datapath. Successor to the fixed 4-bit speed decoder.
- Holds a signed speed index updated by up/down key pulses, with saturation and lock.
- Decodes the index into fast/slow mode and a factor 1..MAX_FACTOR.
- For each output-sample tick, generates the SRAM address advance step and the slow-mode interpolation fraction consumed by the DSP block.

Parameters:
- MAX_FACTOR, 8, largest speed-up/slow-down factor; legal range 2..15.
- SPEED_W, 4, width of o_speed, o_step and o_frac; must hold MAX_FACTOR.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_up  in  1  single-cycle pulse: one step faster
- i_down  in  1  single-cycle pulse: one step slower
- i_norm  in  1  single-cycle pulse: return to 1x
- i_lock  in  1  level; when high, i_up, i_down and i_norm are ignored
- i_tick  in  1  single-cycle pulse per output sample request
- o_fast_or_slow  out  1  1 = fast or normal, 0 = slow
- o_speed  out  SPEED_W  current factor, 1..MAX_FACTOR
- o_adv  out  1  pulse: advance sample address by o_step
- o_step  out  SPEED_W  address increment, valid when o_adv = 1
- o_frac  out  SPEED_W  interpolation numerator, 0..o_speed-1, valid with o_valid
- o_valid  out  1  pulse one cycle after each i_tick

Behaviour:
- Internal state: signed index s, range -(MAX_FACTOR-1)..+(MAX_FACTOR-1), and phase counter p, range 0..MAX_FACTOR-1.
- Reset (async, i_rst_n = 0):
  - s = 0, p = 0.
  - Outputs: o_fast_or_slow = 1, o_speed = 1, o_adv = 0, o_step = 0, o_frac = 0, o_valid = 0.
  - Reset asserted mid-operation aborts any pending o_adv/o_valid; first post-reset tick behaves as 1x.
- Index update, on the clock edge where i_lock = 0; priority order:
  - i_norm: s = 0.
  - i_up and i_down together: no change.
  - i_up: s = min(s+1, MAX_FACTOR-1).
  - i_down: s = max(s-1, -(MAX_FACTOR-1)).
  - Saturation is silent; no wrap-around.
  - Any change to s clears p to 0 in the same cycle.
- Decode, registered, visible the cycle after s changes:
  - o_fast_or_slow = (s >= 0).
  - o_speed = |s| + 1.
- Tick handling. Outputs are registered with latency 1: i_tick at edge N gives o_valid = 1 for the cycle after edge N. Decode uses the s value before any same-edge index change.
  - Fast/normal (s >= 0):
    - o_adv = 1, o_step = s+1, o_frac = 0.
    - p stays 0.
  - Slow (s < 0), factor F = 1-s:
    - o_frac = p, o_step = 1.
    - o_adv = 1 only when p == F-1.
    - p then advances to (p+1) mod F.
  - Net slow-mode effect: exactly one address advance per F ticks.
- Simultaneous i_tick and an index change on the same edge:
  - Tick is processed with the old s and old p.
  - New s takes effect from the next tick; p is cleared, so the clear wins over the increment.
- Without i_tick, o_adv and o_valid are 0; o_step and o_frac hold their last values.
- i_tick on consecutive cycles is legal and produces back-to-back o_valid pulses.

Test Plan:
- Reset, then 3 ticks -> each o_valid with o_adv = 1, o_step = 1, o_frac = 0; o_fast_or_slow = 1, o_speed = 1.
- 3 i_up pulses, then 2 ticks -> o_speed = 4, o_fast_or_slow = 1, two o_adv with o_step = 4.
- i_norm, then 3 i_down, then 8 ticks -> o_fast_or_slow = 0, o_speed = 4; o_frac sequence 0,1,2,3,0,1,2,3; o_adv only on ticks 4 and 8.
- Saturation: 20 i_up pulses -> o_speed = 8, not wrapped. Then 20 i_down pulses -> o_speed = 8, o_fast_or_slow = 0.
- Lock and simultaneous events:
  - i_lock = 1 with i_up pulses -> o_speed unchanged.
  - i_up and i_down on the same cycle -> no change.
  - i_tick together with i_up in slow mode at p = 2 -> that tick reports o_frac = 2; the next tick reports o_frac = 0 at the new speed.
- Async reset asserted mid slow-mode sequence (p = 2, between edges) -> outputs go to reset values immediately; after release, first tick gives o_step = 1, o_frac = 0.
